// File: rtl/fetch_unit.sv
// Instruction fetch: issues 64-byte line reads, buffers beats in a 128-byte ring, presents a 15-byte decode window.
// Latency: first request two cycles after reset release; an accepted beat is visible in the window after that edge.
// Backpressure: requests held until reqack; new lines requested only when a full line of free space exists; respcyc is always acked.
module fetch_unit #(
    parameter int BUF_BYTES  = 128,
    parameter int LINE_BYTES = 64,
    parameter int WINDOW     = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [63:0]           entry,
    input  logic                  redirect,
    input  logic [63:0]           redirect_rip,
    output logic                  reqcyc,
    output logic [63:0]           req,
    output logic [12:0]           reqtag,
    input  logic                  reqack,
    input  logic                  respcyc,
    input  logic [63:0]           resp,
    output logic                  respack,
    output logic                  dec_valid,
    output logic [8*WINDOW-1:0]   dec_bytes,
    output logic [63:0]           dec_rip,
    input  logic [3:0]            dec_consume
);

    localparam int PW = $clog2(BUF_BYTES);   // buffer pointer width
    localparam int AW = PW + 1;              // occupancy counts 0..BUF_BYTES inclusive

    // READ, MEMORY space, no extra attributes
    localparam logic [12:0] REQ_TAG = {1'b1, 4'b0001, 8'h00};

    typedef enum logic [1:0] {
        S_BOOT,
        S_IDLE,
        S_REQ,
        S_RESP
    } state_t;

    state_t          state_q, state_d;
    logic [63:0]     line_addr_q, line_addr_d;
    logic [2:0]      beat_q, beat_d;
    logic [2:0]      skip_beats_q, skip_beats_d;
    logic            first_line_q, first_line_d;
    logic            stale_q, stale_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   avail_q, avail_d;
    logic [63:0]     dec_rip_q, dec_rip_d;

    logic [7:0]      mem_q [BUF_BYTES];

    logic            beat_acc;
    logic            beat_last;
    logic            beat_wr;
    logic            beat_part;
    logic [AW-1:0]   wr_amt;
    logic [3:0]      cons_amt;
    logic            load_en;
    logic [63:0]     load_addr;
    logic            in_flight;

    // Outputs decode registers only; respack is the single combinational pass-through
    assign reqcyc    = (state_q == S_REQ);
    assign req       = line_addr_q;
    assign reqtag    = REQ_TAG;
    assign respack   = respcyc;
    assign dec_valid = (avail_q >= AW'(WINDOW));
    assign dec_rip   = dec_rip_q;

    // Beat classification and byte accounting for this cycle
    always_comb begin
        beat_acc  = (state_q == S_RESP) && respcyc;
        beat_last = beat_acc && (beat_q == 3'd7);
        // Redirect wins over a same-cycle write; leading beats of the first line sit before the entry address
        beat_wr   = beat_acc && !stale_q && !redirect &&
                    !(first_line_q && (beat_q < skip_beats_q));
        // First written beat after a load only contributes bytes from the entry offset onward
        beat_part = first_line_q && (beat_q == skip_beats_q);
        wr_amt    = '0;
        if (beat_wr) begin
            wr_amt = beat_part ? (AW'(8) - AW'(rd_ptr_q[2:0])) : AW'(8);
        end
        cons_amt  = (dec_valid && !redirect) ? dec_consume : 4'd0;
        load_en   = (state_q == S_BOOT) || redirect;
        load_addr = (state_q == S_BOOT) ? entry : redirect_rip;
        in_flight = (state_q == S_REQ) || (state_q == S_RESP);
    end

    // Next-state: bus sequencing, buffer pointers, then load override
    always_comb begin
        state_d      = state_q;
        line_addr_d  = line_addr_q;
        beat_d       = beat_q;
        skip_beats_d = skip_beats_q;
        first_line_d = first_line_q;
        stale_d      = stale_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        avail_d      = avail_q;
        dec_rip_d    = dec_rip_q;

        case (state_q)
            S_BOOT: begin
                state_d = S_IDLE;
            end
            S_IDLE: begin
                // Only ask for a line when all of it will fit
                if (!redirect && (avail_q <= AW'(BUF_BYTES - LINE_BYTES))) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (reqack) begin
                    beat_d  = 3'd0;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (respcyc) begin
                    beat_d = beat_q + 3'd1;
                    if (beat_q == 3'd7) begin
                        state_d = S_IDLE;
                        // A stale line belonged to the old stream; the reloaded line is still unfetched
                        if (!stale_q) begin
                            line_addr_d  = line_addr_q + 64'(LINE_BYTES);
                            first_line_d = 1'b0;
                        end
                        stale_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase

        if (beat_wr) begin
            wr_ptr_d = wr_ptr_q + PW'(8);
        end
        rd_ptr_d  = rd_ptr_q + PW'(cons_amt);
        dec_rip_d = dec_rip_q + 64'(cons_amt);
        avail_d   = avail_q + wr_amt - AW'(cons_amt);

        // Start (or restart) the stream; an outstanding request still finishes but its data is dropped
        if (load_en) begin
            line_addr_d  = load_addr & ~64'(LINE_BYTES - 1);
            skip_beats_d = load_addr[5:3];
            rd_ptr_d     = PW'(load_addr[2:0]);
            wr_ptr_d     = '0;
            avail_d      = '0;
            dec_rip_d    = load_addr;
            first_line_d = 1'b1;
            stale_d      = in_flight && !beat_last;
        end
    end

    // Control and pointer registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_BOOT;
            line_addr_q  <= '0;
            beat_q       <= '0;
            skip_beats_q <= '0;
            first_line_q <= 1'b0;
            stale_q      <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            avail_q      <= '0;
            dec_rip_q    <= '0;
        end else begin
            state_q      <= state_d;
            line_addr_q  <= line_addr_d;
            beat_q       <= beat_d;
            skip_beats_q <= skip_beats_d;
            first_line_q <= first_line_d;
            stale_q      <= stale_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            avail_q      <= avail_d;
            dec_rip_q    <= dec_rip_d;
        end
    end

    // Byte buffer: one 8-byte beat per cycle at an 8-aligned slot, so a beat never straddles the wrap
    always_ff @(posedge clk) begin
        if (beat_wr) begin
            for (int k = 0; k < 8; k++) begin
                mem_q[wr_ptr_q + PW'(k)] <= resp[8*k +: 8];
            end
        end
    end

    // Decode window gathers bytes from rd_ptr, wrapping at the buffer end
    always_comb begin
        dec_bytes = '0;
        for (int i = 0; i < WINDOW; i++) begin
            dec_bytes[8*i +: 8] = mem_q[rd_ptr_q + PW'(i)];
        end
    end

    // Response beats only belong in RESP
    a_resp_in_resp: assert property (@(posedge clk) disable iff (!reset)
        respcyc |-> (state_q == S_RESP));

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic          clk = 1'b0;
    logic          reset;
    logic [63:0]   entry;
    logic          redirect;
    logic [63:0]   redirect_rip;
    logic          reqcyc;
    logic [63:0]   req;
    logic [12:0]   reqtag;
    logic          reqack;
    logic          respcyc;
    logic [63:0]   resp;
    logic          respack;
    logic          dec_valid;
    logic [119:0]  dec_bytes;
    logic [63:0]   dec_rip;
    logic [3:0]    dec_consume;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk          (clk),
        .reset        (reset),
        .entry        (entry),
        .redirect     (redirect),
        .redirect_rip (redirect_rip),
        .reqcyc       (reqcyc),
        .req          (req),
        .reqtag       (reqtag),
        .reqack       (reqack),
        .respcyc      (respcyc),
        .resp         (resp),
        .respack      (respack),
        .dec_valid    (dec_valid),
        .dec_bytes    (dec_bytes),
        .dec_rip      (dec_rip),
        .dec_consume  (dec_consume)
    );

    int           n_cmp = 0;
    int           n_bad = 0;
    int           bus_ph;
    int           bus_bt;
    logic [63:0]  bus_addr;
    logic [63:0]  req_log [$];
    logic [63:0]  exp_rip;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory image: every byte holds the low 8 bits of its own address
    function automatic logic [63:0] beat_data(input logic [63:0] a);
        logic [63:0] d;
        d = '0;
        for (int k = 0; k < 8; k++) d[8*k +: 8] = a[7:0] + 8'(k);
        return d;
    endfunction

    function automatic logic [119:0] win(input logic [63:0] rip);
        logic [119:0] w;
        w = '0;
        for (int i = 0; i < 15; i++) w[8*i +: 8] = rip[7:0] + 8'(i);
        return w;
    endfunction

    // One clock; then sample and advance the bus responder for the next edge
    task automatic tick();
        @(posedge clk);
        #1;
        case (bus_ph)
            0: if (reqcyc) begin
                req_log.push_back(req);
                bus_addr = req;
                reqack   = 1'b1;
                bus_ph   = 1;
            end
            1: begin
                reqack  = 1'b0;
                respcyc = 1'b1;
                bus_bt  = 0;
                resp    = beat_data(bus_addr);
                bus_ph  = 2;
            end
            default: begin
                bus_bt++;
                if (bus_bt == 8) begin
                    respcyc = 1'b0;
                    resp    = '0;
                    bus_ph  = 0;
                end else begin
                    resp = beat_data(bus_addr + 64'(8 * bus_bt));
                end
            end
        endcase
    endtask

    task automatic do_reset(input logic [63:0] ent);
        reset       = 1'b0;
        reqack      = 1'b0;
        respcyc     = 1'b0;
        resp        = '0;
        redirect    = 1'b0;
        redirect_rip = '0;
        dec_consume = 4'd0;
        bus_ph      = 0;
        bus_bt      = 0;
        bus_addr    = '0;
        req_log.delete();
        entry       = ent;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0; entry = 64'h1000; redirect = 1'b0; redirect_rip = '0;
        reqack = 1'b0; respcyc = 1'b0; resp = '0; dec_consume = 4'd0;
        bus_ph = 0; bus_bt = 0; bus_addr = '0;
        #3;
        check_eq("rst_reqcyc", reqcyc, 0);
        check_eq("rst_req", req, 0);
        check_eq("rst_dec_valid", dec_valid, 0);
        check_eq("rst_dec_rip", dec_rip, 0);

        // Aligned entry, no consumption: fill, then boundary at avail 128 / 64
        do_reset(64'h1000);
        tick();
        check_eq("boot_no_req", reqcyc, 0);
        tick();
        check_eq("first_reqcyc", reqcyc, 1);
        check_eq("first_req", req, 64'h1000);
        check_eq("reqtag", reqtag, 13'h1100);
        repeat (9) tick();
        check_eq("l1_valid", dec_valid, 1);
        check_eq("l1_rip", dec_rip, 64'h1000);
        check_eq("l1_window", dec_bytes, win(64'h1000));
        repeat (30) tick();
        check_eq("full_nreq", req_log.size(), 2);
        check_eq("full_req1", req_log[1], 64'h1040);
        check_eq("full_reqcyc", reqcyc, 0);
        check_eq("full_rip", dec_rip, 64'h1000);
        dec_consume = 4'd1;
        repeat (63) tick();
        check_eq("avail65_nreq", req_log.size(), 2);
        tick();
        check_eq("avail64_rip", dec_rip, 64'h1040);
        check_eq("avail64_window", dec_bytes, win(64'h1040));
        dec_consume = 4'd0;
        repeat (3) tick();
        check_eq("avail64_nreq", req_log.size(), 3);
        check_eq("avail64_req", req_log[2], 64'h1080);

        // Misaligned entry: beat 0 skipped, first written beat contributes 5 bytes
        do_reset(64'h100B);
        repeat (6) tick();
        check_eq("mis_b2_invalid", dec_valid, 0);
        tick();
        check_eq("mis_b3_valid", dec_valid, 1);
        check_eq("mis_rip", dec_rip, 64'h100B);
        check_eq("mis_window", dec_bytes, win(64'h100B));
        check_eq("mis_req", req_log[0], 64'h1000);

        // Redirect while beat 3 is on the bus
        do_reset(64'h1000);
        repeat (6) tick();
        check_eq("rd_pre_valid", dec_valid, 1);
        redirect = 1'b1;
        redirect_rip = 64'h2004;
        tick();
        redirect = 1'b0;
        check_eq("rd_valid_drop", dec_valid, 0);
        check_eq("rd_rip", dec_rip, 64'h2004);
        tick();
        check_eq("rd_respack", respack, 1);
        repeat (3) tick();
        check_eq("rd_discard_valid", dec_valid, 0);
        check_eq("rd_idle", reqcyc, 0);
        tick();
        check_eq("rd_new_reqcyc", reqcyc, 1);
        check_eq("rd_new_req", req, 64'h2000);
        repeat (9) tick();
        check_eq("rd_nreq", req_log.size(), 2);
        check_eq("rd_final_valid", dec_valid, 1);
        check_eq("rd_final_rip", dec_rip, 64'h2004);
        check_eq("rd_final_window", dec_bytes, win(64'h2004));

        // Asynchronous reset mid-response, then restart from a new entry
        do_reset(64'h1000);
        repeat (5) tick();
        check_eq("ar_pre_valid", dec_valid, 1);
        #2;
        reset = 1'b0;
        #1;
        check_eq("ar_reqcyc", reqcyc, 0);
        check_eq("ar_valid", dec_valid, 0);
        check_eq("ar_rip", dec_rip, 0);
        do_reset(64'h3000);
        repeat (2) tick();
        check_eq("ar_re_reqcyc", reqcyc, 1);
        check_eq("ar_re_req", req, 64'h3000);
        repeat (9) tick();
        check_eq("ar_re_rip", dec_rip, 64'h3000);
        check_eq("ar_re_window", dec_bytes, win(64'h3000));

        // Streaming consumption of 15 bytes per cycle across many ring wraps
        do_reset(64'h1000);
        dec_consume = 4'd15;
        exp_rip = 64'h1000;
        for (int c = 0; c < 400; c++) begin
            tick();
            if (dec_valid) begin
                check_eq("st_rip", dec_rip, exp_rip);
                check_eq("st_window", dec_bytes, win(exp_rip));
                exp_rip = exp_rip + 64'd15;
            end
        end
        check_eq("st_progress", exp_rip > 64'h1400, 1);
        for (int i = 0; i < req_log.size(); i++) begin
            check_eq("st_req_seq", req_log[i], 64'h1000 + 64'(64 * i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
